pulse_meter: RTL
================

// Module: pulse_meter
// PURPOSE
//  Downstream consumer of pulse_gen's pulse output; same clock domain, no synchronizer.
//  Counts rising edges of pulse over a programmable window and measures edge-to-edge period.
//  Each window result is presented on a valid/ready output for the checker or status logic.
// PARAMETERS
//  CNT_W  8   width of per-window pulse count (saturating)
//  PER_W  16  width of period measurement and timeout limit (saturating)
//  WIN_W  16  width of window length
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  rst          in   1      asynchronous reset, active-high
//  pulse        in   1      pulse stream from pulse_gen, synchronous to clk
//  enable       in   1      1 = run measurement windows, 0 = abort/idle
//  win_len      in   WIN_W  window length in clk cycles, sampled at window start
//  timeout_lim  in   PER_W  missing-pulse limit in cycles (used only with timeout feature)
//  meas_count   out  CNT_W  rising edges seen in last completed window
//  meas_period  out  PER_W  last completed rise-to-rise interval, in cycles
//  meas_ovf     out  1      meas_count saturated during last window
//  meas_valid   out  1      result valid; held until accepted
//  meas_ready   in   1      consumer accepts result when meas_valid & meas_ready
//  timeout      out  1      no rise for timeout_lim cycles
// BEHAVIOUR
//  - Reset: all outputs 0, pulse_d=0, FSM=IDLE, counters 0, period tracker disarmed.
//  - Edge detect: rise = pulse & ~pulse_d; pulse_d registers pulse every cycle. A pulse held
//    high for many cycles is one rise. Rise is counted in the same edge it is sampled.
//  - FSM IDLE: enable=1 -> COUNT; latch win_len (0 treated as 1); clear win_cnt, pcnt, ovf.
//  - FSM COUNT: win_cnt++ each cycle; rise -> pcnt++ saturating at 2^CNT_W-1, ovf set on any
//    rise while pcnt is at max. On cycle win_cnt==len-1 (rise in that cycle counted):
//    meas_count<=pcnt(+rise), meas_ovf<=ovf, meas_period<=last interval, meas_valid<=1, -> HOLD.
//    enable=0 in COUNT -> IDLE, partial window discarded, no valid.
//  - FSM HOLD: outputs stable, meas_valid=1 until meas_ready=1. Rises in HOLD are not counted.
//    On handshake: meas_valid<=0 in next cycle; -> COUNT (new window, win_len resampled) if
//    enable=1, else IDLE. enable=0 during HOLD does not drop the pending result.
//  - Handshake: meas_ready may be high before valid; never depends combinationally on valid.
//  - Period tracker runs in every state except reset: first rise arms it, clears per_cnt.
//    Each later rise: interval = per_cnt+1 stored, per_cnt cleared. per_cnt saturates at
//    2^PER_W-1; saturated interval reported as all-ones. enable=0 disarms tracker.
//  - Window length min 1, max 2^WIN_W-1; back-to-back windows lose exactly one cycle
//    (the handshake cycle) when meas_ready is held high.
//  - rst mid-window or mid-HOLD: immediate clear, pending result lost.
// CONFIGURATION
//  PULSE_METER_TIMEOUT_EN defined: while tracker armed and enable=1, timeout asserts when
//    per_cnt reaches timeout_lim with no rise; sticky until next rise (cleared same edge) or
//    enable=0. timeout_lim=0 disables detection.
//  Not defined: timeout tied 0, timeout_lim ignored, no extra logic.
// TESTING
//  1 rst=1 mid-COUNT with pulses active -> all outputs 0 next cycle; rst release -> IDLE.
//  2 pulse 1-high every 10 cycles, win_len=100, ready=1 -> count=10, period=10, valid 1 cycle.
//  3 same stimulus, ready=0 for 50 cycles -> valid/count/period stable 50 cycles; pulses
//    not counted; after handshake next window count=10.
//  4 CNT_W=4, pulse toggling every cycle, win_len=64 -> count=15, ovf=1; pulse held
//    high whole window -> count=1 (edge in window) or 0.
//  5 enable dropped at win_cnt=50 of 100 -> no valid, FSM IDLE; win_len=0 -> 1-cycle windows.
//  6 TIMEOUT_EN, timeout_lim=20, pulses stop -> timeout=1 exactly 20 cycles after last rise;
//    next rise clears it; without macro timeout stays 0.

Source files
------------

// File: rtl/pulse_meter.sv
// Windowed rising-edge counter and rise-to-rise period meter, with results on a valid/ready output.
// Optional missing-pulse timeout detector enabled by defining PULSE_METER_TIMEOUT_EN.
module pulse_meter #(
    parameter int CNT_W = 8,
    parameter int PER_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    input  logic             enable,
    input  logic [WIN_W-1:0] win_len,
    input  logic [PER_W-1:0] timeout_lim,
    output logic [CNT_W-1:0] meas_count,
    output logic [PER_W-1:0] meas_period,
    output logic             meas_ovf,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HOLD
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PER_W-1:0] PER_MAX = '1;

    state_e           state_q, state_d;
    logic             pulse_prev_q;
    logic [WIN_W-1:0] len_q, len_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             ovf_q, ovf_d;
    logic             armed_q, armed_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [PER_W-1:0] last_per_q, last_per_d;
    logic [CNT_W-1:0] meas_count_q, meas_count_d;
    logic [PER_W-1:0] meas_period_q, meas_period_d;
    logic             meas_ovf_q, meas_ovf_d;
    logic             meas_valid_q, meas_valid_d;
    logic             rise;
    logic             start_win;

    assign rise = pulse & ~pulse_prev_q;

    // Period tracker: independent of the window FSM, only enable gates it.
    always_comb begin
        armed_d    = armed_q;
        per_cnt_d  = per_cnt_q;
        last_per_d = last_per_q;
        if (!enable) begin
            armed_d   = 1'b0;
            per_cnt_d = '0;
        end else if (rise) begin
            armed_d   = 1'b1;
            per_cnt_d = '0;
            if (armed_q) begin
                last_per_d = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + 1'b1;
            end
        end else if (armed_q && per_cnt_q != PER_MAX) begin
            per_cnt_d = per_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        win_cnt_d     = win_cnt_q;
        pcnt_d        = pcnt_q;
        ovf_d         = ovf_q;
        meas_count_d  = meas_count_q;
        meas_period_d = meas_period_q;
        meas_ovf_d    = meas_ovf_q;
        meas_valid_d  = meas_valid_q;
        start_win     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    start_win = 1'b1;
                end
            end
            ST_COUNT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                    if (rise) begin
                        if (pcnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            pcnt_d = pcnt_q + 1'b1;
                        end
                    end
                    // Final cycle publishes this cycle's rise and period update as well.
                    if (win_cnt_q == len_q - 1'b1) begin
                        meas_count_d  = pcnt_d;
                        meas_ovf_d    = ovf_d;
                        meas_period_d = last_per_d;
                        meas_valid_d  = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (meas_ready) begin
                    meas_valid_d = 1'b0;
                    if (enable) begin
                        start_win = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_win) begin
            state_d   = ST_COUNT;
            len_d     = (win_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : win_len;
            win_cnt_d = '0;
            pcnt_d    = '0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pulse_prev_q  <= 1'b0;
            len_q         <= '0;
            win_cnt_q     <= '0;
            pcnt_q        <= '0;
            ovf_q         <= 1'b0;
            armed_q       <= 1'b0;
            per_cnt_q     <= '0;
            last_per_q    <= '0;
            meas_count_q  <= '0;
            meas_period_q <= '0;
            meas_ovf_q    <= 1'b0;
            meas_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pulse_prev_q  <= pulse;
            len_q         <= len_d;
            win_cnt_q     <= win_cnt_d;
            pcnt_q        <= pcnt_d;
            ovf_q         <= ovf_d;
            armed_q       <= armed_d;
            per_cnt_q     <= per_cnt_d;
            last_per_q    <= last_per_d;
            meas_count_q  <= meas_count_d;
            meas_period_q <= meas_period_d;
            meas_ovf_q    <= meas_ovf_d;
            meas_valid_q  <= meas_valid_d;
        end
    end

    assign meas_count  = meas_count_q;
    assign meas_period = meas_period_q;
    assign meas_ovf    = meas_ovf_q;
    assign meas_valid  = meas_valid_q;

`ifdef PULSE_METER_TIMEOUT_EN
    logic timeout_q, timeout_d;

    // Sticky until the next rise or enable drop; compares against the post-edge count.
    always_comb begin
        timeout_d = timeout_q;
        if (!enable || rise) begin
            timeout_d = 1'b0;
        end else if (armed_q && timeout_lim != '0 && per_cnt_d == timeout_lim) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_lim;
    assign unused_timeout_lim = ^timeout_lim;
    assign timeout = 1'b0;
`endif

endmodule
